// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-addressed SRAM responder with programmable wait states and a
// two-cycle ERROR response for illegal size, misaligned or out-of-range accesses.
module ahb_lite_sram_slave #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [WIDTH-1:0] HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [WIDTH-1:0] HWDATA,
  input  logic             HREADY,
  output logic [WIDTH-1:0] HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [2:0]       dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Handshake: an address phase is taken only on an edge where HSEL, HREADY
  // and HTRANS[1] are all high; a data phase ends on the edge where HREADYOUT is high.

  state_t           state, next_state;
  logic [3:0]       cnt, cnt_next;
  logic [AW-1:0]    idx;
  logic             write_q;
  logic             accept;
  logic             xfer_err;
  logic [22:0]      word_sel;
  logic [WIDTH-1:0] mem [DEPTH];

  logic unused_bits;
  assign unused_bits = ^{HADDR[WIDTH-1:24], HTRANS[0]};

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign word_sel = {1'b0, HADDR[23:2]};
  assign xfer_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) || (word_sel >= 23'(DEPTH));

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      ST_WAIT: begin
        if (cnt == 4'd0) next_state = ST_DATA;
        else             cnt_next   = cnt - 4'd1;
      end
      ST_ERR1: next_state = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all drive HREADYOUT high, so a new address phase may land here.
        if (accept) begin
          if (xfer_err) begin
            next_state = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            next_state = ST_WAIT;
            cnt_next   = WS_LOAD;
          end else begin
            next_state = ST_DATA;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      idx     <= '0;
      write_q <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (accept && HREADYOUT) begin
        idx     <= HADDR[AW+1:2];
        write_q <= HWRITE;
      end
    end
  end

  // Storage is not reset; the write commits on the edge that closes the data phase.
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && write_q) mem[idx] <= HWDATA;
  end

  assign HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
  assign HRDATA    = (state == ST_DATA && !write_q) ? mem[idx] : '0;
  assign dbg_state = state;

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder: a word-addressed SRAM slave with programmable wait states and a two-cycle ERROR response.
- Sits behind the system address decoder. Its HRDATA/HREADYOUT/HRESP feed one slot of the slave-to-master response multiplexer.
- Selected region is HADDR[31:24], decoded externally. This block uses only HADDR[23:0].

Parameters:
- WIDTH, 32, data and address bus width.
- DEPTH, 256, number of WIDTH-bit words of storage (power of two, 2..2^22).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- HSEL  input  1  slave select from the address decoder.
- HADDR  input  WIDTH  address-phase address.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size; only 3'b010 (word) is legal.
- HWDATA  input  WIDTH  write data, valid in the data phase.
- HREADY  input  1  bus-level ready (output of the response mux).
- HRDATA  output  WIDTH  read data.
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Accept: a transfer is accepted at a rising edge where HSEL & HREADY & HTRANS[1] are all high. On acceptance, register the word index HADDR[23:2], HWRITE, and an error flag.
- Error flag: set if HSIZE != 3'b010, or HADDR[1:0] != 0, or HADDR[23:2] >= DEPTH.
- Non-transfer cycles: IDLE/BUSY, or HSEL low with HREADY high, leave or return the FSM to ST_IDLE. No access occurs.
- FSM states: ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2.
- ST_IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
- Accept with error flag set: go to ST_ERR1, regardless of WAIT_STATES.
- Accept with OKAY and WAIT_STATES>0: go to ST_WAIT, load the counter with WAIT_STATES-1.
- Accept with OKAY and WAIT_STATES=0: go to ST_DATA.
- ST_WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0, go to ST_DATA. Total low cycles = WAIT_STATES exactly.
- ST_DATA: HREADYOUT=1, HRESP=0.
  - Read: HRDATA = mem[index].
  - Write: mem[index] <= HWDATA at the closing edge.
  - Next state is decided by the same accept rule, so back-to-back transfers run with no bubble.
- ST_ERR1: HREADYOUT=0, HRESP=1. Always goes to ST_ERR2.
- ST_ERR2: HREADYOUT=1, HRESP=1. Next state by the accept rule.
- Errored transfers never write memory. HRDATA=0 during error and wait cycles.
- HRDATA is 0 whenever the output is not a read ST_DATA cycle.
- Write-then-read to the same address back-to-back: the read returns the newly written data. The write commits on the same edge that captures the read address.
- Accept rule when HREADYOUT=0 in ST_WAIT/ST_ERR1: HREADY is low, so nothing is accepted. Address-phase inputs in those cycles are ignored.
- HSEL dropping during a data phase has no effect; the data phase completes normally.
- Reset (asynchronous assert, any state):
  - FSM to ST_IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0.
  - An in-flight write is discarded.
  - Memory contents are not reset.
- Latency: a read completes WAIT_STATES+1 cycles after its address phase.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x01000010, then read 0x01000010 back-to-back. Required: HREADYOUT stays 1, HRESP=0, HRDATA=0xDEADBEEF in the read data phase, one cycle after that address phase.
- WAIT_STATES=3: read a word previously written 0x12345678. Required: HREADYOUT low for exactly 3 cycles, then 1 with HRDATA=0x12345678 and HRESP=0.
- HSIZE=3'b001 write to 0x01000004 holding 0xAAAAAAAA. Required: cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1, then a read returns 0xAAAAAAAA.
- DEPTH=256, read of 0x01000400 (index 256). Required: two-cycle ERROR, HRDATA=0. Same pattern for unaligned address 0x01000002.
- IDLE and BUSY with HSEL=1, then NONSEQ with HSEL=0. Required: HREADYOUT=1, HRESP=0 every cycle, no memory change.
- WAIT_STATES=3: assert HRESETn low during the second wait cycle of a write of 0x55555555 to a word holding 0x11111111. Required: outputs go immediately to HREADYOUT=1, HRESP=0, HRDATA=0, and a later read returns 0x11111111.
